mag_window_acc: RTL and testbench

- Downstream consumer of the 16-bit absolute-value stage. It takes unsigned magnitudes (range 0..32768; 0x8000 is +32768, not negative) over a valid/ready handshake.
- It accumulates them over a window of 2^WIN_LOG2 samples, or fewer if an early flush is requested.
- It presents the window sum, peak and sample count on a registered valid/ready output.
- Used as the envelope/energy front end after abs16.

---
 rtl/mag_window_acc.sv | 110 +++++++++++
 tb/tb_mag_window_acc.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mag_window_acc.sv
// Windowed sum / peak / count of unsigned magnitudes, closed on a full window or an early flush.
// Optional peak tracker: define MAG_WINDOW_ACC_PEAK_EN to build it; otherwise out_peak is tied to 0.
// Handshakes: a transfer happens on a rising edge where valid && ready; ready never depends on the same-cycle valid.
module mag_window_acc #(
  parameter int WIN_LOG2 = 4,
  parameter int ACC_W    = 16 + WIN_LOG2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [15:0]         in_mag,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ACC_W-1:0]    out_sum,
  output logic [15:0]         out_peak,
  output logic [WIN_LOG2:0]   out_cnt
);

  localparam int CNT_W = WIN_LOG2 + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(1) << WIN_LOG2;

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   out_sum_q;
  logic [CNT_W-1:0]   out_cnt_q;
  logic               out_valid_q;
  logic               accept;
  logic               close;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ACCUM;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM: if (close)     state_d = HOLD;
      HOLD:  if (out_ready) state_d = ACCUM;
      default:              state_d = ACCUM;
    endcase
  end

  // Output / control decode; the closing sample is folded into sum_d and cnt_d
  always_comb begin
    in_ready = (state_q == ACCUM);
    accept   = in_valid && in_ready;
    sum_d    = sum_q + (accept ? ACC_W'(in_mag) : '0);
    cnt_d    = cnt_q + CNT_W'(accept);
    close    = in_ready && ((accept && (cnt_d == FULL_CNT)) || (flush && (cnt_d != '0)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q       <= '0;
      cnt_q       <= '0;
      out_sum_q   <= '0;
      out_cnt_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (close) begin
        out_sum_q   <= sum_d;
        out_cnt_q   <= cnt_d;
        out_valid_q <= 1'b1;
        sum_q       <= '0;
        cnt_q       <= '0;
      end else if (accept) begin
        sum_q <= sum_d;
        cnt_q <= cnt_d;
      end
      if ((state_q == HOLD) && out_ready) out_valid_q <= 1'b0;
    end
  end

`ifdef MAG_WINDOW_ACC_PEAK_EN
  logic [15:0] peak_q, peak_d, out_peak_q;

  always_comb begin
    peak_d = (accept && (in_mag > peak_q)) ? in_mag : peak_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      peak_q     <= '0;
      out_peak_q <= '0;
    end else if (close) begin
      out_peak_q <= peak_d;
      peak_q     <= '0;
    end else if (accept) begin
      peak_q <= peak_d;
    end
  end

  assign out_peak = out_peak_q;
`else
  assign out_peak = '0;
`endif

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_cnt   = out_cnt_q;

endmodule

// File: tb/tb_mag_window_acc.sv
// Bench for mag_window_acc: queue-based window model compared every cycle, directed literal checks,
// randomized traffic with resets, and a result scoreboard drained on each output handshake.
module tb_mag_window_acc;
  localparam int WIN_LOG2 = 4;
  localparam int ACC_W    = 16 + WIN_LOG2;
  localparam int WIN_N    = 1 << WIN_LOG2;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [15:0]         in_mag = '0;
  logic                flush = 1'b0;
  logic                out_valid;
  logic                out_ready = 1'b1;
  logic [ACC_W-1:0]    out_sum;
  logic [15:0]         out_peak;
  logic [WIN_LOG2:0]   out_cnt;

  int total = 0;
  int bad   = 0;
  bit started = 1'b0;

  mag_window_acc #(.WIN_LOG2(WIN_LOG2), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_mag(in_mag), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_peak(out_peak), .out_cnt(out_cnt)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pk(input logic [15:0] v);
`ifdef MAG_WINDOW_ACC_PEAK_EN
    return 32'(v);
`else
    return 32'(v & 16'h0);
`endif
  endfunction

  // Behavioural model: window contents kept as a list, results computed when the window closes
  logic [15:0]       win[$];
  logic [ACC_W-1:0]  exp_q[$];
  bit                m_hold = 1'b0;
  bit                m_valid = 1'b0;
  longint            m_sum = 0;
  int                m_peak = 0;
  int                m_cnt = 0;

  always @(posedge clk) begin
    if (rst) begin
      win.delete(); exp_q.delete();
      m_hold = 1'b0; m_valid = 1'b0; m_sum = 0; m_peak = 0; m_cnt = 0;
    end else if (!m_hold) begin
      if (in_valid) win.push_back(in_mag);
      if ((in_valid && win.size() == WIN_N) || (flush && win.size() > 0)) begin
        m_sum = 0; m_peak = 0;
        foreach (win[i]) begin
          m_sum += win[i];
          if (int'(win[i]) > m_peak) m_peak = win[i];
        end
        m_peak = int'(pk(16'(m_peak)));
        m_cnt = win.size();
        m_valid = 1'b1;
        m_hold = 1'b1;
        exp_q.push_back(ACC_W'(m_sum));
        win.delete();
      end
    end else if (out_ready) begin
      m_valid = 1'b0;
      m_hold = 1'b0;
    end
  end

  // Per-cycle compare against the model, plus scoreboard drain on handshake
  logic [ACC_W-1:0] sb_exp;
  always @(negedge clk) begin
    if (started) begin
      cmp("cyc_in_ready", 32'(in_ready), 32'(!m_hold));
      cmp("cyc_out_valid", 32'(out_valid), 32'(m_valid));
      cmp("cyc_out_sum", 32'(out_sum), 32'(m_sum));
      cmp("cyc_out_peak", 32'(out_peak), 32'(m_peak));
      cmp("cyc_out_cnt", 32'(out_cnt), 32'(m_cnt));
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          cmp("sb_unexpected_result", 32'(out_valid), 32'(0));
        end else begin
          sb_exp = exp_q.pop_front();
          cmp("sb_sum", 32'(out_sum), 32'(sb_exp));
        end
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_window(input int base, input int step);
    in_valid = 1'b1;
    for (int i = 0; i < WIN_N; i++) begin
      in_mag = 16'(base + i * step);
      tick();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b1;
    tick();
    started = 1'b1;
    cmp("rst_in_ready", 32'(in_ready), 32'd1);
    cmp("rst_out_valid", 32'(out_valid), 32'd0);
    cmp("rst_out_sum", 32'(out_sum), 32'd0);
    cmp("rst_out_cnt", 32'(out_cnt), 32'd0);
    rst = 1'b0;
    tick();

    // Full window of maximum magnitude
    send_window(32'h8000, 0);
    cmp("full_valid", 32'(out_valid), 32'd1);
    cmp("full_sum", 32'(out_sum), 32'd524288);
    cmp("full_peak", 32'(out_peak), pk(16'h8000));
    cmp("full_cnt", 32'(out_cnt), 32'd16);
    cmp("full_in_ready_hold", 32'(in_ready), 32'd0);
    tick();
    cmp("full_in_ready_after", 32'(in_ready), 32'd1);
    cmp("full_valid_after", 32'(out_valid), 32'd0);

    // Early flush after 1,2,3
    in_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin in_mag = 16'(i); tick(); end
    in_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    cmp("flush_valid", 32'(out_valid), 32'd1);
    cmp("flush_sum", 32'(out_sum), 32'd6);
    cmp("flush_peak", 32'(out_peak), pk(16'd3));
    cmp("flush_cnt", 32'(out_cnt), 32'd3);
    tick();

    // Flush together with the first sample, then a flush on an empty window
    in_valid = 1'b1; in_mag = 16'd5; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    cmp("flush1_sum", 32'(out_sum), 32'd5);
    cmp("flush1_peak", 32'(out_peak), pk(16'd5));
    cmp("flush1_cnt", 32'(out_cnt), 32'd1);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    cmp("empty_flush_valid", 32'(out_valid), 32'd0);
    cmp("empty_flush_in_ready", 32'(in_ready), 32'd1);
    tick();

    // Backpressure: result held for 5 cycles, input pulses ignored
    out_ready = 1'b0;
    send_window(0, 1);
    for (int k = 0; k < 5; k++) begin
      cmp("bp_valid", 32'(out_valid), 32'd1);
      cmp("bp_sum", 32'(out_sum), 32'd120);
      cmp("bp_peak", 32'(out_peak), pk(16'd15));
      cmp("bp_cnt", 32'(out_cnt), 32'd16);
      cmp("bp_in_ready", 32'(in_ready), 32'd0);
      in_valid = k[0]; in_mag = 16'd999;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    cmp("bp_release_in_ready", 32'(in_ready), 32'd1);
    cmp("bp_release_valid", 32'(out_valid), 32'd0);
    cmp("bp_keep_sum", 32'(out_sum), 32'd120);

    // Reset mid-window discards the partial sum
    in_valid = 1'b1; in_mag = 16'd100;
    for (int i = 0; i < 7; i++) tick();
    in_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    cmp("midrst_valid", 32'(out_valid), 32'd0);
    cmp("midrst_sum", 32'(out_sum), 32'd0);
    send_window(1, 0);
    cmp("midrst_win_sum", 32'(out_sum), 32'd16);
    cmp("midrst_win_peak", 32'(out_peak), pk(16'd1));
    cmp("midrst_win_cnt", 32'(out_cnt), 32'd16);
    tick();

    // Largest code plus ones
    in_valid = 1'b1; in_mag = 16'hFFFF;
    tick();
    in_mag = 16'd1;
    for (int i = 0; i < WIN_N - 1; i++) tick();
    in_valid = 1'b0;
    cmp("ffff_sum", 32'(out_sum), 32'd65550);
    cmp("ffff_peak", 32'(out_peak), pk(16'hFFFF));
    cmp("ffff_cnt", 32'(out_cnt), 32'd16);
    tick();

    // Randomized traffic with flush, backpressure and occasional reset
    for (int c = 0; c < 4000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_mag    = 16'($urandom_range(0, 32768));
      flush     = ($urandom_range(0, 9) == 0);
      out_ready = ($urandom_range(0, 1) == 1);
      rst       = ($urandom_range(0, 299) == 0);
      tick();
    end
    in_valid = 1'b0; flush = 1'b0; rst = 1'b0; out_ready = 1'b1;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
